// File: rtl/nn_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the ECG classifier layer blocks.
//   nn_state_e : sequencing states of a time-multiplexed neuron
//                (ACC = accumulate beats, RQ = requantise, OUT = present result)
//   NN_DW      : layer-wide default activation/output width
//   sat_round  : round-half-up, arithmetic right shift and saturation of a
//                wide accumulator to a signed dw-bit range. The result is
//                returned sign-extended to 64 bits so that the caller can pick
//                its own width.
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int NN_DW = 8;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RQ  = 2'd1,
    OUT = 2'd2
  } nn_state_e;

  // acc must already be sign-extended to 64 bits. shift and dw are expected to
  // be elaboration-time constants, so all shifts below collapse to wiring.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int unsigned        shift,
                                                   input int unsigned        dw);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r = acc;
    // Adding half an LSB before the floor shift gives round-half-up.
    if (shift > 0) begin
      r = r + (64'sd1 <<< (shift - 1));
    end
    r     = r >>> shift;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (r > max_v) begin
      r = max_v;
    end else if (r < min_v) begin
      r = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_requant.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nn_requant
// Purely combinational requantiser: rounds a full-precision accumulator
// (round half up), drops SHIFT fractional bits, saturates to a signed DW-bit
// range and optionally clamps negative results to zero (ReLU).
//
// Parameters
//   ACC_W   : accumulator width (< 64)
//   DW      : output width
//   SHIFT   : fractional bits removed
//   RELU_EN : 1 = negative results become 0, 0 = signed result passes
// Ports
//   acc_i   in  ACC_W  signed accumulator value
//   res_o   out DW     requantised result
// -----------------------------------------------------------------------------
module nn_requant
  import nn_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int DW      = NN_DW,
  parameter int SHIFT   = 7,
  parameter int RELU_EN = 1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [DW-1:0]    res_o
);

  logic signed [63:0] acc_wide;
  logic signed [63:0] sat;
  logic               sat_neg;
  // After saturation the bits above DW-1 are copies of the sign bit, so only
  // the low DW bits carry information; the rest is folded into a dummy.
  logic               sat_hi_unused;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here unconditionally, elsewhere via defaults at the top) so that no
  // latch is inferred.
  always_comb begin
    acc_wide = {{(64-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    sat      = sat_round(acc_wide, SHIFT, DW);
    sat_neg  = sat[63];
    if ((RELU_EN != 0) && sat_neg) begin
      res_o = '0;
    end else begin
      res_o = sat[DW-1:0];
    end
  end

  assign sat_hi_unused = ^sat[62:DW];

endmodule

// File: rtl/mac_neuron_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mac_neuron_seq
// Time-multiplexed fully-connected neuron. One signed multiplier streams N_IN
// activations against a programmable weight file; the bias is pre-scaled by
// 2^SHIFT and folded into the first product. After the last beat the full
// precision sum is requantised by nn_requant (round, saturate, optional ReLU)
// and offered on a valid/ready output. Vector length is defined by the beat
// count; in_last is only cross-checked and reported on frame_err.
//
// Timing: last beat accepted in cycle t -> RQ in t+1 -> out_valid in t+2.
// Throughput with out_ready held high: one vector per N_IN+2 cycles.
//
// Ports
//   clk        in   1      clock
//   reset      in   1      synchronous, active-high reset
//   wt_we      in   1      weight/bias write strobe (accepted in any state)
//   wt_addr    in   AW     0..N_IN-1 = weight, N_IN = bias, others ignored
//   wt_data    in   WW     signed weight/bias value
//   in_valid   in   1      activation beat valid
//   in_ready   out  1      activation beat accepted (only in ACC)
//   in_data    in   DW     signed activation
//   in_last    in   1      final beat marker (checked, not used for length)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts the result
//   out_data   out  DW     requantised result, held while out_valid && !out_ready
//   frame_err  out  1      one-cycle pulse after a beat with wrong in_last
// -----------------------------------------------------------------------------
module mac_neuron_seq
  import nn_pkg::*;
#(
  parameter int N_IN    = 15,
  parameter int DW      = NN_DW,
  parameter int WW      = 8,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 7,
  parameter int RELU_EN = 1,
  parameter int AW      = $clog2(N_IN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wt_we,
  input  logic [AW-1:0] wt_addr,
  input  logic [WW-1:0] wt_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          frame_err
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(N_IN - 1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  nn_state_e               state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [WW-1:0]    w_q [N_IN];
  logic signed [WW-1:0]    w_d [N_IN];
  logic signed [WW-1:0]    bias_q, bias_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    frame_err_q, frame_err_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                    beat_fire;
  logic                    is_last;
  logic signed [DW-1:0]    x_s;
  logic signed [DW+WW-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_term;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [DW-1:0]    rq_res;

  always_comb begin
    beat_fire = in_valid && in_ready_q;
    is_last   = (idx_q == LAST_IDX);
    x_s       = in_data;
    // The weight file is read from the registered copy, so a write landing in
    // the same cycle is seen only from the next read onwards.
    prod      = x_s * w_q[idx_q];
    prod_ext  = {{(ACC_W-DW-WW){prod[DW+WW-1]}}, prod};
    // Bias carries the same SHIFT fractional bits as the products.
    bias_term = {{(ACC_W-WW){bias_q[WW-1]}}, bias_q} <<< SHIFT;
    acc_base  = (idx_q == '0) ? bias_term : acc_q;
  end

  nn_requant #(
    .ACC_W  (ACC_W),
    .DW     (DW),
    .SHIFT  (SHIFT),
    .RELU_EN(RELU_EN)
  ) u_requant (
    .acc_i(acc_q),
    .res_o(rq_res)
  );

  // ---------------------------------------------------------------------------
  // Weight / bias file update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_d    = w_q;
    bias_d = bias_q;
    if (wt_we) begin
      if (wt_addr < BIAS_ADDR) begin
        w_d[wt_addr] = wt_data;
      end else if (wt_addr == BIAS_ADDR) begin
        bias_d = wt_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    frame_err_d = 1'b0;

    case (state_q)
      ACC: begin
        if (beat_fire) begin
          acc_d       = acc_base + prod_ext;
          frame_err_d = (in_last != is_last);
          if (is_last) begin
            idx_d   = '0;
            state_d = RQ;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      RQ: begin
        out_data_d  = rq_res;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: begin
        state_d = ACC;
        idx_d   = '0;
      end
    endcase

    // in_ready is registered: it reflects the state being entered.
    in_ready_d = (state_d == ACC);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACC;
      idx_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      bias_q      <= '0;
      // NOTE: the weight file has to read as all-zero after reset, so it is
      // built from resettable flops rather than a RAM macro; each entry is
      // cleared explicitly.
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
      bias_q      <= bias_d;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mac_neuron_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mac_neuron_seq
// Directed and randomized stimulus for mac_neuron_seq. Two instances share all
// inputs: one with ReLU enabled, one with ReLU disabled. Expected results come
// from a plain integer dot-product model of the neuron.
// -----------------------------------------------------------------------------
module tb_mac_neuron_seq;

  localparam int N_IN  = 15;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int ACC_W = 24;
  localparam int SHIFT = 7;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wt_we;
  logic [AW-1:0] wt_addr;
  logic [WW-1:0] wt_data;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_ready;

  logic          in_ready,    in_ready_nr;
  logic          out_valid,   out_valid_nr;
  logic [DW-1:0] out_data,    out_data_nr;
  logic          frame_err,   frame_err_nr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: weights, bias and the current activation vector.
  int mw [N_IN];
  int mb;
  int vx [N_IN];

  always #5 clk = ~clk;

  mac_neuron_seq #(
    .N_IN(N_IN), .DW(DW), .WW(WW), .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU_EN(1), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_err(frame_err)
  );

  mac_neuron_seq #(
    .N_IN(N_IN), .DW(DW), .WW(WW), .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU_EN(0), .AW(AW)
  ) dut_nr (
    .clk(clk), .reset(reset),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .in_valid(in_valid), .in_ready(in_ready_nr), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_nr), .out_ready(out_ready), .out_data(out_data_nr),
    .frame_err(frame_err_nr)
  );

  // ---------------------------------------------------------------------------
  // Reference model: integer dot product, floor((sum + half) / 2^SHIFT), clamp.
  // ---------------------------------------------------------------------------
  function automatic int golden(input bit relu);
    longint s, num, q, scale, hi, lo;
    scale = longint'(1) << SHIFT;
    s = longint'(mb) * scale;
    for (int i = 0; i < N_IN; i++) s += longint'(vx[i]) * longint'(mw[i]);
    num = s + scale / 2;
    q   = num / scale;
    if ((num % scale) != 0 && num < 0) q -= 1;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction

  function automatic int rand8();
    int v;
    v = int'($urandom_range(255, 0));
    return (v > 127) ? v - 256 : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    wt_we     = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
    mb = 0;
    check("rst_in_ready",     32'(in_ready),     32'd1);
    check("rst_in_ready_nr",  32'(in_ready_nr),  32'd1);
    check("rst_out_valid",    32'(out_valid),    32'd0);
    check("rst_out_data",     32'(out_data),     32'd0);
    check("rst_frame_err",    32'(frame_err),    32'd0);
  endtask

  task automatic write_w(input int addr, input int val);
    wt_we   = 1'b1;
    wt_addr = AW'(addr);
    wt_data = WW'(val);
    tick();
    wt_we = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < N_IN; a++) write_w(a, mw[a]);
    write_w(N_IN, mb);
  endtask

  // Sends vx[0..n_beats-1]. in_last is raised on beat last_pos (-1 = never).
  // If coll_beat >= 0, w[3] is written with coll_val in the cycle that beat is
  // accepted.
  task automatic send_vector(input int n_beats, input int last_pos, input int gap,
                             input int coll_beat, input int coll_val);
    int waits;
    for (int i = 0; i < n_beats; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(vx[i]);
      in_last  = (i == last_pos);
      if (i == coll_beat) begin
        wt_we   = 1'b1;
        wt_addr = AW'(3);
        wt_data = WW'(coll_val);
      end
      waits = 0;
      while (!in_ready && waits < 50) begin
        tick();
        waits++;
      end
      check("beat_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      wt_we    = 1'b0;
      check("frame_err", 32'(frame_err), 32'((i == last_pos) != (i == N_IN - 1)));
      if (i < N_IN - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check("gap_in_ready",  32'(in_ready),  32'd1);
          check("gap_frame_err", 32'(frame_err), 32'd0);
        end
      end
    end
    if (n_beats == N_IN) begin
      check("rq_in_ready",  32'(in_ready),  32'd0);
      check("rq_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  // Called right after send_vector: expects out_valid in the next cycle
  // (two cycles after the last beat), holds out_ready low for 'hold' cycles.
  task automatic receive(input int hold);
    logic [7:0] e1, e0;
    e1 = 8'(golden(1'b1));
    e0 = 8'(golden(1'b0));
    tick();
    check("out_valid_rise",    32'(out_valid),    32'd1);
    check("out_valid_rise_nr", 32'(out_valid_nr), 32'd1);
    check("out_data",          32'(out_data),     32'(e1));
    check("out_data_norelu",   32'(out_data_nr),  32'(e0));
    check("out_in_ready",      32'(in_ready),     32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_data",     32'(out_data),  32'(e1));
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready",  32'(in_ready),  32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    wt_we     = 1'b0;
    wt_addr   = '0;
    wt_data   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    do_reset();

    // Weight file cleared by reset: any vector gives zero.
    for (int i = 0; i < N_IN; i++) vx[i] = rand8();
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(0);

    // Nominal: w=0x20, bias=3, x=0x10 -> sum 8064 -> 0x3F.
    for (int i = 0; i < N_IN; i++) begin mw[i] = 32; vx[i] = 16; end
    mb = 3;
    load_all();
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(0);

    // Positive saturation.
    for (int i = 0; i < N_IN; i++) begin mw[i] = 127; vx[i] = 127; end
    mb = 0;
    load_all();
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(0);

    // Negative saturation: ReLU instance 0x00, plain instance 0x80.
    for (int i = 0; i < N_IN; i++) mw[i] = -128;
    load_all();
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(0);

    // Backpressure and input gaps with the nominal setup; next vector follows
    // immediately after the output handshake.
    for (int i = 0; i < N_IN; i++) begin mw[i] = 32; vx[i] = 16; end
    mb = 3;
    load_all();
    send_vector(N_IN, N_IN - 1, 3, -1, 0);
    receive(5);
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(0);

    // Framing errors: early in_last, then missing in_last.
    for (int i = 0; i < N_IN; i++) vx[i] = rand8();
    send_vector(N_IN, 9, 0, -1, 0);
    receive(0);
    for (int i = 0; i < N_IN; i++) vx[i] = rand8();
    send_vector(N_IN, -1, 1, -1, 0);
    receive(1);

    // Reset mid-vector, reload, full vector.
    for (int i = 0; i < N_IN; i++) begin mw[i] = rand8(); vx[i] = rand8(); end
    mb = rand8();
    load_all();
    send_vector(7, N_IN - 1, 0, -1, 0);
    do_reset();
    for (int i = 0; i < N_IN; i++) begin mw[i] = rand8(); vx[i] = rand8(); end
    mb = rand8();
    load_all();
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(2);

    // Write collision on w[3] while beat 3 is consumed: old value this vector,
    // new value on the next one.
    for (int i = 0; i < N_IN; i++) begin mw[i] = rand8(); vx[i] = rand8(); end
    mw[3] = 100;
    vx[3] = 64;
    mb    = rand8();
    load_all();
    send_vector(N_IN, N_IN - 1, 0, 3, 1);
    receive(0);
    mw[3] = 1;
    for (int i = 0; i < N_IN; i++) vx[i] = rand8();
    vx[3] = 64;
    send_vector(N_IN, N_IN - 1, 0, -1, 0);
    receive(0);

    // Randomized vectors, gaps and backpressure.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N_IN; i++) begin mw[i] = rand8(); vx[i] = rand8(); end
      mb = rand8();
      load_all();
      send_vector(N_IN, N_IN - 1, int'($urandom_range(2, 0)), -1, 0);
      receive(int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_neuron_seq.md
Name: mac_neuron_seq

Overview:
- Parametrised, time-multiplexed fully-connected neuron for the ECG classifier layers.
- Replaces the fixed 15-input, fully-parallel node. A single multiplier streams N_IN activations against a programmable weight/bias register file.
- Accumulates at full precision, then rounds, saturates and optionally applies ReLU.
- Input and output use valid/ready handshakes so nodes can be chained or share a layer sequencer.

Parameters:
- N_IN, 15, number of inputs per vector (>=2)
- DW, 8, signed activation and output width
- WW, 8, signed weight/bias width
- ACC_W, 24, signed accumulator width; must be >= DW+WW+clog2(N_IN)+2
- SHIFT, 7, fractional bits removed at requantisation (0..ACC_W-DW)
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result
- AW, clog2(N_IN+1), weight-file address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wt_we  in  1  weight/bias write strobe
- wt_addr  in  AW  0..N_IN-1 selects a weight; N_IN selects the bias; other values are ignored
- wt_data  in  WW  signed weight/bias value
- in_valid  in  1  activation beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  DW  signed activation
- in_last  in  1  marks the final beat of the vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DW  requantised result
- frame_err  out  1  one-cycle pulse on an in_last mismatch

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=ACC, idx=0, acc=0.
  - in_ready=1 on the first cycle after reset. out_valid=0, out_data=0, frame_err=0.
  - All weights and the bias are cleared to 0.
  - Reset mid-vector or mid-output discards the partial vector or pending result.
- State ACC:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - On the first accepted beat (idx==0): acc = (sext(bias)<<SHIFT) + in_data*w[0].
  - On later beats: acc = acc + in_data*w[idx].
  - The product is a full DW+WW signed product, sign-extended to ACC_W. idx increments per beat.
  - On the beat with idx==N_IN-1: go to RQ and set idx=0.
  - The vector length is set by the beat count only.
  - frame_err pulses the cycle after any accepted beat where in_last != (idx==N_IN-1). Accumulation is unaffected.
- State RQ (one cycle, in_ready=0):
  - r = acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0), then arithmetic shift right by SHIFT (round half up).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - If RELU_EN and the result is negative, force 0.
  - Register the result into out_data, set out_valid=1, go to OUT.
- State OUT:
  - in_ready=0; out_data is held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next cycle, go to ACC.
  - out_data keeps its last value; it is defined only while out_valid=1.
- Latency: the last beat is accepted at cycle t, out_valid rises at t+2.
  - Throughput is one vector per N_IN+2 cycles with out_ready held high.
- Weight writes:
  - Accepted in any state.
  - The MAC reads the pre-write value when the same address is written and read in the same cycle; the new value applies from the next read.
  - A write to an address already consumed in the current vector affects the next vector only.
- Never produce X on out_data or any handshake output after reset.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum {ACC, RQ, OUT};
  - the function sat_round(acc, SHIFT, DW);
  - the constant NN_DW=8 for layer-wide defaults.
- One sub-module, nn_requant (combinational round + saturate + ReLU), so other layer blocks can reuse it.
- The weight file and FSM stay in mac_neuron_seq.

Test Plan:
- Nominal case:
  - Stimulus: defaults, all w=0x20, bias=0x03, 15 beats of 0x10 with in_last on beat 15.
  - Response: acc=8064, out_data=0x3F, out_valid at t+2, frame_err never asserted.
- Positive saturation:
  - Stimulus: all w=0x7F, inputs 0x7F, bias 0.
  - Response: out_data=0x7F.
- Negative saturation and ReLU:
  - Stimulus: all w=0x80, inputs 0x7F, bias 0.
  - Response: RELU_EN=1 gives out_data=0x00; RELU_EN=0 gives 0x80.
- Backpressure and gaps:
  - Stimulus: in_valid gaps of 3 cycles between beats, then out_ready low for 5 cycles after out_valid.
  - Response: same result as the nominal case; out_data stable; in_ready=0 throughout RQ/OUT; next vector accepted the cycle after the out handshake.
- Framing errors:
  - Stimulus: in_last on beat 10, and separately absent on beat 15.
  - Response: frame_err pulses once per mismatch; result still equals the 15-beat sum.
- Reset mid-vector and write collision:
  - Stimulus: reset after 7 beats, reload weights, full vector; separately, write w[3]=0x01 while beat 3 is consumed.
  - Response: the post-reset result matches the golden model; the current vector uses the old w[3] and the next vector uses 0x01.
